// File: rtl/otp_pkg.sv
// Shared constants and helpers for the one-time-pad cipher: stream modes,
// default Galois LFSR taps/seeds per width and seed sanitising.
package otp_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [7:0]  SEED_8  = 8'h01;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'h0001;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] SEED_32 = 32'h0000_0001;

  // Maximal-length masks for the common widths; other widths fall back to the 8-bit mask.
  function automatic logic [63:0] default_taps(input int w);
    case (w)
      16:      return 64'(TAPS_16);
      32:      return 64'(TAPS_32);
      default: return 64'(TAPS_8);
    endcase
  endfunction

  function automatic logic [63:0] default_seed(input int w);
    case (w)
      16:      return 64'(SEED_16);
      32:      return 64'(SEED_32);
      default: return 64'(SEED_8);
    endcase
  endfunction

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1.
  function automatic logic [63:0] seed_sanitise(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Galois LFSR pad source; advances one step per cycle with step=1, holds otherwise.
// Latency: state is the current pad; the stepped value is visible after the edge.
module otp_lfsr
  import otp_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] TAPS = DATA_W'(default_taps(DATA_W)),
  parameter logic [DATA_W-1:0] SEED = DATA_W'(default_seed(DATA_W))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [DATA_W-1:0] state
);

  localparam logic [DATA_W-1:0] SEED_OK = DATA_W'(seed_sanitise(64'(SEED)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_OK;
    end else if (step) begin
      state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
    end
  end

endmodule

// File: rtl/otp_stream_cipher.sv
// One-time-pad engine: encrypt issues a fresh LFSR pad into a slot, decrypt consumes it once.
// Latency 1 cycle, 1 beat/cycle; a held output (out_valid & ~out_ready) stalls the input.
module otp_stream_cipher
  import otp_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                PAD_DEPTH = 8,
  localparam int               IDX_W     = $clog2(PAD_DEPTH),
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(default_taps(DATA_W)),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(default_seed(DATA_W))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_err,
  output logic [IDX_W:0]    pad_count
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
    logic [IDX_W-1:0]  idx;
    logic              err;
  } out_t;

  logic [DATA_W-1:0] slot_val [PAD_DEPTH];
  logic [PAD_DEPTH-1:0] slot_live;
  logic [IDX_W-1:0]  wp;
  logic [DATA_W-1:0] pad;
  out_t              out_q;

  logic accept;
  logic enc_fire;
  logic dec_fire;
  logic dec_hit;

  // Encrypt stalls when the next slot still holds an unconsumed pad; decrypt never does.
  assign in_ready = en & ~clear & (~out_q.vld | out_ready)
                  & ((in_mode == MODE_DEC) | ~slot_live[wp]);
  assign accept   = in_valid & in_ready;
  assign enc_fire = accept & (in_mode == MODE_ENC);
  assign dec_fire = accept & (in_mode == MODE_DEC);
  assign dec_hit  = dec_fire & slot_live[in_index];

  otp_lfsr #(
    .DATA_W (DATA_W),
    .TAPS   (LFSR_TAPS),
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (enc_fire),
    .state (pad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAD_DEPTH; i++) slot_val[i] <= '0;
      slot_live <= '0;
      wp        <= '0;
      out_q     <= '0;
      pad_count <= '0;
    end else if (clear) begin
      // The LFSR keeps running across a clear so no pad value is ever reissued.
      for (int i = 0; i < PAD_DEPTH; i++) slot_val[i] <= '0;
      slot_live <= '0;
      wp        <= '0;
      out_q.vld <= 1'b0;
      pad_count <= '0;
    end else begin
      if (out_q.vld & out_ready) out_q.vld <= 1'b0;
      if (enc_fire) begin
        slot_val[wp]  <= pad;
        slot_live[wp] <= 1'b1;
        out_q         <= '{vld: 1'b1, dat: in_data ^ pad, idx: wp, err: 1'b0};
        wp            <= wp + IDX_W'(1);
        pad_count     <= pad_count + (IDX_W+1)'(1);
      end else if (dec_hit) begin
        slot_val[in_index]  <= '0;
        slot_live[in_index] <= 1'b0;
        out_q     <= '{vld: 1'b1, dat: in_data ^ slot_val[in_index], idx: in_index, err: 1'b0};
        pad_count <= pad_count - (IDX_W+1)'(1);
      end else if (dec_fire) begin
        out_q <= '{vld: 1'b1, dat: '0, idx: in_index, err: 1'b1};
      end
    end
  end

  assign out_valid = out_q.vld;
  assign out_data  = out_q.dat;
  assign out_index = out_q.idx;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_otp_stream_cipher.sv
// Directed scenarios plus randomized traffic against a pad-pool reference model.
module tb_otp_stream_cipher;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          rst, en, clear, in_valid, in_mode, out_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_index;
  logic          in_ready, out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic [IW:0]   pad_count;

  int tests = 0;
  int fails = 0;

  otp_stream_cipher dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_index(in_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_err(out_err), .pad_count(pad_count)
  );

  always #5 clk = ~clk;

  // Reference model: a pool of issued pads indexed by slot, plus the n-th pad of the sequence.
  logic [DW-1:0] seq [$];
  logic [DW-1:0] m_pad [DEPTH];
  bit            m_live [DEPTH];
  int            m_wp, m_n, m_oi;
  bit            m_ov, m_oe, m_known;
  logic [DW-1:0] m_od;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pad_at(input int n);
    while (seq.size() <= n) begin
      logic [DW-1:0] s;
      s = seq[seq.size()-1];
      seq.push_back(s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1));
    end
    return seq[n];
  endfunction

  function automatic int live_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_live[i]) c++;
    return c;
  endfunction

  function automatic bit model_rdy();
    return en && !clear && (!m_ov || out_ready) && (in_mode || !m_live[m_wp]);
  endfunction

  task automatic model_step();
    bit acc;
    acc = in_valid && model_rdy();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_pad[i] = '0; m_live[i] = 0; end
      m_wp = 0; m_n = 0; m_ov = 0; m_od = '0; m_oi = 0; m_oe = 0; m_known = 1;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin m_pad[i] = '0; m_live[i] = 0; end
      m_wp = 0; m_ov = 0;
    end else begin
      if (m_ov && out_ready) m_ov = 0;
      if (acc && !in_mode) begin
        m_pad[m_wp] = pad_at(m_n);
        m_live[m_wp] = 1;
        m_od = in_data ^ pad_at(m_n);
        m_oi = m_wp; m_oe = 0; m_ov = 1;
        m_n++;
        m_wp = (m_wp + 1) % DEPTH;
      end else if (acc && m_live[in_index]) begin
        m_od = in_data ^ m_pad[in_index];
        m_oi = int'(in_index); m_oe = 0; m_ov = 1;
        m_pad[in_index] = '0; m_live[in_index] = 0;
      end else if (acc) begin
        m_od = '0; m_oi = int'(in_index); m_oe = 1; m_ov = 1;
      end
    end
  endtask

  // One cycle: check in_ready mid-cycle, advance the model at the edge, check outputs #1 later.
  task automatic tick();
    #3;
    if (m_known) chk("in_ready", in_ready, model_rdy());
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("pad_count", pad_count, live_count());
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_index", out_index, m_oi);
      chk("out_err", out_err, m_oe);
    end
  endtask

  task automatic drive(input bit v, input bit mode, input logic [DW-1:0] d, input logic [IW-1:0] idx);
    in_valid = v; in_mode = mode; in_data = d; in_index = idx;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; en = 1'b1; out_ready = 1'b1;
    drive(0, 0, 8'h00, 3'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    seq.push_back(8'h01);
    m_known = 0;
    rst = 1'b1; en = 1'b1; clear = 1'b0; out_ready = 1'b1;
    drive(0, 0, 8'h00, 3'd0);
    @(posedge clk); #1;
    do_reset();
    chk("rst_count", pad_count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);

    // Basic encrypt path
    drive(1, 0, 8'hA5, 3'd0); tick();
    chk("t1_data0", out_data, 8'hA4);
    chk("t1_idx0", out_index, 0);
    drive(1, 0, 8'h00, 3'd0); tick();
    chk("t1_data1", out_data, 8'hB8);
    chk("t1_idx1", out_index, 1);
    chk("t1_count", pad_count, 2);
    chk("t1_err", out_err, 0);

    // Decrypt consumes the pad; replay is rejected
    drive(1, 1, 8'hB8, 3'd1); tick();
    chk("t2_data", out_data, 8'h00);
    chk("t2_err", out_err, 0);
    chk("t2_count", pad_count, 1);
    tick();
    chk("t2_replay_err", out_err, 1);
    chk("t2_replay_data", out_data, 8'h00);
    chk("t2_replay_count", pad_count, 1);

    // Pad buffer full
    do_reset();
    repeat (8) begin drive(1, 0, 8'h00, 3'd0); tick(); end
    chk("t3_count", pad_count, 8);
    drive(0, 0, 8'h00, 3'd0); #1;
    chk("t3_full_stall", in_ready, 0);
    drive(1, 1, 8'h00, 3'd0); tick();
    drive(0, 0, 8'h00, 3'd0); #1;
    chk("t3_unblock", in_ready, 1);
    drive(1, 0, 8'h00, 3'd0); tick();
    chk("t3_ninth_idx", out_index, 0);
    chk("t3_ninth_pad", out_data, 8'h64);
    chk("t3_ninth_count", pad_count, 8);

    // Output backpressure
    do_reset();
    drive(1, 0, 8'h00, 3'd0); tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t4_hold_data", out_data, 8'h01);
      chk("t4_hold_idx", out_index, 0);
      chk("t4_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1; tick();
    chk("t4_next_pad", out_data, 8'hB8);
    chk("t4_next_idx", out_index, 1);

    // Clear flushes slots but not the pad sequence
    do_reset();
    drive(1, 0, 8'h00, 3'd0); tick(); tick();
    clear = 1'b1; drive(0, 0, 8'h00, 3'd0); tick(); clear = 1'b0;
    chk("t5_count", pad_count, 0);
    chk("t5_valid", out_valid, 0);
    drive(1, 1, 8'h00, 3'd0); tick();
    chk("t5_dead_err", out_err, 1);
    drive(1, 0, 8'h00, 3'd0); tick();
    chk("t5_idx", out_index, 0);
    chk("t5_pad", out_data, 8'h5C);

    // Reset while output is held
    do_reset();
    drive(1, 0, 8'h00, 3'd0); tick();
    out_ready = 1'b0; drive(0, 0, 8'h00, 3'd0); tick();
    chk("t6_held", out_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_valid", out_valid, 0);
    chk("t6_count", pad_count, 0);
    out_ready = 1'b1; drive(1, 0, 8'h00, 3'd0); tick();
    chk("t6_data", out_data, 8'h01);
    chk("t6_idx", out_index, 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(199) == 0);
      clear     = ($urandom_range(39) == 0);
      en        = ($urandom_range(9) != 0);
      out_ready = ($urandom_range(3) != 0);
      drive($urandom_range(3) != 0, $urandom_range(1), DW'($urandom), IW'($urandom));
      tick();
    end
    rst = 1'b0; clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
